// File: rtl/stack_alu_sequencer_if.sv
// Command bus between the sequencer (master) and the stack ALU (slave).
// stk_opcode nonzero is a one-cycle command; the stack has no ready or back-pressure.
interface stack_alu_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    logic [2:0]             stk_opcode;
    logic [WIDTH-1:0]       stk_in;
    logic [WIDTH-1:0]       stk_out;
    logic                   stk_overflow;
    logic [$clog2(DEPTH):0] stk_index;

    modport master (
        output stk_opcode, stk_in,
        input  stk_out, stk_overflow, stk_index
    );

    modport slave (
        input  stk_opcode, stk_in,
        output stk_out, stk_overflow, stk_index
    );
endinterface

// File: rtl/stack_alu_sequencer.sv
// Runs a loaded (opcode, operand) program against the stack ALU, one instruction
// every three cycles, with a shadow depth check before each issue.
module stack_alu_sequencer #(
    parameter int WIDTH      = 4,
    parameter int DEPTH      = 4,
    parameter int PROG_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          prog_we,
    input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
    input  logic [2:0]                    prog_opcode,
    input  logic [WIDTH-1:0]              prog_data,
    input  logic [$clog2(PROG_DEPTH):0]   prog_len,
    input  logic                          start,
    stack_alu_sequencer_if.master         stk,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [1:0]                    err_code,
    output logic [WIDTH-1:0]              result,
    output logic [2:0]                    dbg_state
);
    localparam int AW = $clog2(PROG_DEPTH);
    localparam int LW = AW + 1;
    localparam int SW = $clog2(DEPTH) + 1;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_MUL  = 3'd5;
    localparam logic [2:0] OP_PUSH = 3'd6;
    localparam logic [2:0] OP_POP  = 3'd7;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        FETCH       = 3'd1,
        CHECK_ISSUE = 3'd2,
        SETTLE      = 3'd3,
        FINISH      = 3'd4
    } state_t;

    logic [2:0]       opc_mem [PROG_DEPTH];
    logic [WIDTH-1:0] dat_mem [PROG_DEPTH];

    state_t           state;
    logic [LW-1:0]    pc;
    logic [LW-1:0]    len;
    logic [SW-1:0]    shadow;
    logic [2:0]       ir_opcode;
    logic [1:0]       ir_err;

    logic [2:0]       f_opcode;
    logic [WIDTH-1:0] f_data;
    logic [1:0]       f_err;
    logic [LW-1:0]    len_clamped;
    logic [LW-1:0]    pc_next;

    // The program buffer is deliberately not reset; it is frozen while a run is active.
    always_ff @(posedge clk) begin
        if (prog_we && !busy) begin
            opc_mem[prog_addr] <= prog_opcode;
            dat_mem[prog_addr] <= prog_data;
        end
    end

    // The pre-issue check is evaluated during FETCH so the issued opcode can be registered.
    always_comb begin
        f_opcode = opc_mem[pc[AW-1:0]];
        f_data   = dat_mem[pc[AW-1:0]];
        f_err    = 2'd0;
        case (f_opcode)
            OP_NOP:         f_err = 2'd0;
            OP_PUSH:        if (shadow == SW'(DEPTH)) f_err = 2'd1;
            OP_POP:         if (shadow == '0) f_err = 2'd2;
            OP_ADD, OP_MUL: if (shadow < SW'(2)) f_err = 2'd2;
            default:        f_err = 2'd3;
        endcase
        len_clamped = (prog_len > LW'(PROG_DEPTH)) ? LW'(PROG_DEPTH) : prog_len;
        pc_next     = pc + LW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            pc             <= '0;
            len            <= '0;
            shadow         <= '0;
            ir_opcode      <= OP_NOP;
            ir_err         <= 2'd0;
            stk.stk_opcode <= OP_NOP;
            stk.stk_in     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            err_code       <= 2'd0;
            result         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_clamped != '0) begin
                            len      <= len_clamped;
                            pc       <= '0;
                            shadow   <= stk.stk_index;
                            error    <= 1'b0;
                            err_code <= 2'd0;
                            busy     <= 1'b1;
                            state    <= FETCH;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    ir_opcode <= f_opcode;
                    ir_err    <= f_err;
                    if (f_err == 2'd0) begin
                        stk.stk_opcode <= f_opcode;
                        stk.stk_in     <= f_data;
                    end
                    state <= CHECK_ISSUE;
                end
                CHECK_ISSUE: begin
                    stk.stk_opcode <= OP_NOP;
                    if (ir_err != 2'd0) begin
                        error    <= 1'b1;
                        err_code <= ir_err;
                        done     <= 1'b1;
                        state    <= FINISH;
                    end else begin
                        case (ir_opcode)
                            OP_PUSH:                shadow <= shadow + SW'(1);
                            OP_POP, OP_ADD, OP_MUL: shadow <= shadow - SW'(1);
                            default:                shadow <= shadow;
                        endcase
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (stk.stk_overflow) begin
                        error    <= 1'b1;
                        err_code <= 2'd3;
                        done     <= 1'b1;
                        state    <= FINISH;
                    end else begin
                        pc <= pc_next;
                        if (pc_next == len) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FINISH: begin
                    if (!error) result <= stk.stk_out;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;
endmodule
